// File: rtl/isp_gamma_mc.sv
// Per-channel gamma LUT for a DVP pixel stream, with double-buffered tables.
// Table swaps and enable changes take effect only at frame start.
module isp_gamma_mc #(
    parameter int BITS_IN  = 8,
    parameter int BITS_OUT = 8,
    parameter int CHANNELS = 3
) (
    input  logic                         pclk,
    input  logic                         rst,
    input  logic                         in_href,
    input  logic                         in_vsync,
    input  logic [CHANNELS*BITS_IN-1:0]  in_data,
    output logic                         out_href,
    output logic                         out_vsync,
    output logic [CHANNELS*BITS_OUT-1:0] out_data,
    input  logic                         cfg_enable,
    input  logic                         cfg_wen,
    input  logic [1:0]                   cfg_chan,
    input  logic [BITS_IN-1:0]           cfg_addr,
    input  logic [BITS_OUT-1:0]          cfg_wdata,
    input  logic                         cfg_commit,
    output logic [BITS_OUT-1:0]          cfg_rdata,
    output logic                         cfg_pending
);

    localparam int DEPTH = 1 << BITS_IN;
    localparam int DW_IN = CHANNELS * BITS_IN;
    localparam int DW_OUT = CHANNELS * BITS_OUT;

    logic              vsync_prev_q;
    logic              frame_start;
    logic              active_sel_q, active_sel_d;
    logic              pending_q, pending_d;
    logic              enable_q, enable_d;

    logic              s1_href_q;
    logic              s1_vsync_q;
    logic              s1_en_q;
    logic [DW_IN-1:0]  s1_data_q;

    logic [DW_OUT-1:0] rd_all;
    logic [DW_OUT-1:0] byp_all;
    logic [DW_OUT-1:0] rb_all;

    logic              out_href_q;
    logic              out_vsync_q;
    logic [DW_OUT-1:0] out_data_q, out_data_d;
    logic [BITS_OUT-1:0] rdata_q, rdata_d;

    assign frame_start = in_vsync & ~vsync_prev_q;

    // A commit landing on the frame-start cycle swaps immediately.
    always_comb begin
        active_sel_d = active_sel_q;
        pending_d    = pending_q;
        enable_d     = enable_q;
        if (frame_start) begin
            enable_d = cfg_enable;
            if (pending_q || cfg_commit) begin
                active_sel_d = ~active_sel_q;
                pending_d    = 1'b0;
            end
        end else if (cfg_commit) begin
            pending_d = 1'b1;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [BITS_OUT-1:0] mem_q [2*DEPTH];
        logic [BITS_OUT-1:0] rd_q;
        logic [BITS_IN-1:0]  pix_s1;

        // Table contents are intentionally not reset.
        always_ff @(posedge pclk) begin
            if (cfg_wen && (cfg_chan == 2'(c))) begin
                mem_q[{~active_sel_q, cfg_addr}] <= cfg_wdata;
            end
            rd_q <= mem_q[{active_sel_q, in_data[c*BITS_IN +: BITS_IN]}];
        end

        assign pix_s1 = s1_data_q[c*BITS_IN +: BITS_IN];

        if (BITS_OUT >= BITS_IN) begin : g_up
            assign byp_all[c*BITS_OUT +: BITS_OUT] =
                BITS_OUT'(pix_s1) << (BITS_OUT - BITS_IN);
        end else begin : g_dn
            assign byp_all[c*BITS_OUT +: BITS_OUT] =
                pix_s1[BITS_IN-1 -: BITS_OUT];
        end

        assign rd_all[c*BITS_OUT +: BITS_OUT] = rd_q;
        assign rb_all[c*BITS_OUT +: BITS_OUT] =
            mem_q[{~active_sel_q, cfg_addr}];
    end

    always_comb begin
        rdata_d = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (cfg_chan == 2'(c)) begin
                rdata_d = rb_all[c*BITS_OUT +: BITS_OUT];
            end
        end
    end

    always_comb begin
        out_data_d = '0;
        if (s1_href_q) begin
            out_data_d = s1_en_q ? rd_all : byp_all;
        end
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            vsync_prev_q <= 1'b0;
            active_sel_q <= 1'b0;
            pending_q    <= 1'b0;
            enable_q     <= 1'b0;
            s1_href_q    <= 1'b0;
            s1_vsync_q   <= 1'b0;
            s1_en_q      <= 1'b0;
            s1_data_q    <= '0;
            out_href_q   <= 1'b0;
            out_vsync_q  <= 1'b0;
            out_data_q   <= '0;
            rdata_q      <= '0;
        end else begin
            vsync_prev_q <= in_vsync;
            active_sel_q <= active_sel_d;
            pending_q    <= pending_d;
            enable_q     <= enable_d;
            s1_href_q    <= in_href;
            s1_vsync_q   <= in_vsync;
            s1_en_q      <= enable_q;
            s1_data_q    <= in_data;
            out_href_q   <= s1_href_q;
            out_vsync_q  <= s1_vsync_q;
            out_data_q   <= out_data_d;
            rdata_q      <= rdata_d;
        end
    end

    assign out_href    = out_href_q;
    assign out_vsync   = out_vsync_q;
    assign out_data    = out_data_q;
    assign cfg_rdata   = rdata_q;
    assign cfg_pending = pending_q;

endmodule

// File: doc/isp_gamma_mc.md
ISP_GAMMA_MC -- requirements
Module: isp_gamma_mc

Interface
REQ-001 SHALL have parameter BITS_IN, default 8, input pixel component width (8..12).
REQ-002 SHALL have parameter BITS_OUT, default 8, output pixel component width (8..12).
REQ-003 SHALL have parameter CHANNELS, default 3, number of components per pixel (1..4).
REQ-004 SHALL have port pclk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous assert, active-high.
REQ-006 SHALL have port in_href  input  1  line-valid of input DVP stream.
REQ-007 SHALL have port in_vsync  input  1  frame sync of input DVP stream, active-high.
REQ-008 SHALL have port in_data  input  CHANNELS*BITS_IN  pixel; channel c at bits [c*BITS_IN +: BITS_IN].
REQ-009 SHALL have port out_href  output  1  in_href delayed by the pipeline latency.
REQ-010 SHALL have port out_vsync  output  1  in_vsync delayed by the pipeline latency.
REQ-011 SHALL have port out_data  output  CHANNELS*BITS_OUT  mapped pixel, same channel packing.
REQ-012 SHALL have port cfg_enable  input  1  requested gamma enable (0 = bypass).
REQ-013 SHALL have port cfg_wen  input  1  table write strobe, one entry per cycle.
REQ-014 SHALL have port cfg_chan  input  2  channel selected for write/readback.
REQ-015 SHALL have port cfg_addr  input  BITS_IN  table index for write/readback.
REQ-016 SHALL have port cfg_wdata  input  BITS_OUT  table entry value.
REQ-017 SHALL have port cfg_commit  input  1  single-cycle pulse: request shadow→active swap.
REQ-018 SHALL have port cfg_rdata  output  BITS_OUT  shadow-bank entry at (cfg_chan, cfg_addr), 1-cycle latency.
REQ-019 SHALL have port cfg_pending  output  1  commit requested, swap not yet performed.

Function
REQ-020 SHALL hold two banks per channel, each 2^BITS_IN entries of BITS_OUT; bank select active_sel (1 bit) chooses the active bank, ~active_sel is the shadow.
REQ-021 SHALL perform cfg_wen writes only into the shadow bank as indexed by active_sel at the start of that cycle; cfg_chan >= CHANNELS writes ignored, readback returns 0.
REQ-022 SHALL detect frame start as in_vsync 0→1 (registered previous value, reset 0).
REQ-023 SHALL set cfg_pending on the cycle after cfg_commit=1; cfg_commit while pending has no further effect.
REQ-024 SHALL, at a frame-start cycle with cfg_pending=1 or cfg_commit=1, toggle active_sel and clear cfg_pending (visible next cycle); commit coincident with frame start swaps at that edge.
REQ-025 SHALL latch cfg_enable into enable_active at every frame start; mid-frame changes of cfg_enable SHALL NOT affect the current frame.
REQ-026 SHALL have fixed latency 2 cycles for data, href and vsync in both enabled and bypass modes.
REQ-027 SHALL, stage 1: register in_data, in_href, in_vsync and issue per-channel table reads from the active bank; stage 2: register table outputs (enabled) or bypass value (disabled).
REQ-028 SHALL form bypass value per channel: BITS_OUT >= BITS_IN → {in, (BITS_OUT-BITS_IN) zeros}; else in[BITS_IN-1 -: BITS_OUT].
REQ-029 SHALL drive out_data to 0 whenever the delayed href is 0.
REQ-030 SHALL apply a swap only to pixels entering stage 1 after the swap edge; pixels already in flight use the previous bank.
REQ-031 SHALL accept table writes at any time, including during active lines, without disturbing the active bank.

Reset
REQ-032 SHALL, on rst=1, immediately clear out_href, out_vsync, out_data, cfg_rdata, cfg_pending, active_sel, enable_active and the vsync edge register to 0.
REQ-033 SHALL NOT reset table contents; they are undefined until written and unchanged across rst.
REQ-034 SHALL discard a pending commit when rst asserts mid-operation; swap requires a new cfg_commit.

Verification (BITS_IN=8, BITS_OUT=8, CHANNELS=3 unless noted)
REQ-035 SHALL cover: rst asserted mid-line → all outputs 0 within the same cycle, cfg_pending=0, bypass active after release.
REQ-036 SHALL cover: load identity into all 3 channels, commit, cfg_enable=1, vsync rise, pixel 0x302010 → out_data 0x302010 exactly 2 cycles later with out_href aligned.
REQ-037 SHALL cover: mid-frame load inverse (v→255-v) and commit → current frame still identity, cfg_pending=1; after next vsync rise, 0x302010 → 0xCFDFEF.
REQ-038 SHALL cover: cfg_commit on the same cycle as vsync rise → swap at that edge, cfg_pending never observed 1.
REQ-039 SHALL cover: cfg_enable=0 latched at frame start, BITS_IN=8, BITS_OUT=10, channel value 0xA5 → 0x294; BITS_IN=10, BITS_OUT=8, 0x3FF → 0xFF.
REQ-040 SHALL cover: write chan=1 addr=0x40 data=0x77, read back → cfg_rdata=0x77 one cycle later; chan=3 write ignored, readback 0.
